// File: rtl/bipolar_stream_pkg.sv
// Shared types and width helpers for the bipolar stochastic-stream decoder.
// Accumulator and output-shift widths derive from BW/WINLOG through these helpers.
package bipolar_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int DEF_BW     = 8;
   localparam int DEF_WINLOG = 8;

   // Signed sum of up to 2^winlog steps of +/-1 needs winlog+2 bits to hold +/-2^winlog.
   function automatic int acc_width(input int winlog);
      return winlog + 2;
   endfunction

   // Maps a sum in [-2^winlog, 2^winlog] onto the BW-bit range +/-2^(bw-1).
   function automatic int out_shift(input int bw, input int winlog);
      return winlog - bw + 1;
   endfunction

   localparam int DEF_ACC_W = acc_width(DEF_WINLOG);
   localparam int DEF_SHIFT = out_shift(DEF_BW, DEF_WINLOG);

endpackage

// File: rtl/bipolar_updown_cnt.sv
// Signed +/-1 up/down accumulator with synchronous clear (priority) and enable.
// Clear or reset zeroes the count on the next rising edge; o_cnt is registered.
module bipolar_updown_cnt #(
   parameter int WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic                    i_up,
   output logic signed [WIDTH-1:0] o_cnt
);

   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

   logic signed [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= i_up ? (r_cnt + ONE) : (r_cnt - ONE);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/bipolar_stream_decode.sv
// Decodes a window of 2^WINLOG bipolar stochastic bits into a BW-bit signed value.
// Result registered one cycle after the last accepted bit; held in HOLD until out_ready.
module bipolar_stream_decode
   import bipolar_stream_pkg::*;
#(
   parameter int BW     = 8,
   parameter int WINLOG = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cont,
   input  logic          in_valid,
   input  logic          bit_in,
   output logic          in_ready,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [BW-1:0] out_value,
   output logic          busy
);

   localparam int ACC_W = acc_width(WINLOG);
   localparam int SH    = out_shift(BW, WINLOG);

   state_t                  r_state;
   logic [WINLOG-1:0]       r_cnt;
   logic [BW-1:0]           r_out;

   logic signed [ACC_W-1:0] w_acc;
   logic signed [ACC_W-1:0] w_step;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_shift;
   logic                    w_acc_en;
   logic                    w_acc_clr;
   logic                    w_last;
   logic                    w_pos_ovf;
   logic [BW-1:0]           w_result;

   // A start in ACCUM discards the bit presented with it, so it gates the enable.
   assign w_acc_en  = (r_state == ST_ACCUM) && in_valid && !start;
   assign w_acc_clr = (start && (r_state != ST_HOLD))
                    || ((r_state == ST_HOLD) && out_ready && cont);
   assign w_last    = w_acc_en && (r_cnt == '1);

   bipolar_updown_cnt #(
      .WIDTH (ACC_W)
   ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_acc_clr),
      .i_en  (w_acc_en),
      .i_up  (bit_in),
      .o_cnt (w_acc)
   );

   // Final sum includes the completing bit, which the accumulator has not yet absorbed.
   assign w_step    = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};
   assign w_sum     = w_acc + w_step;
   assign w_shift   = w_sum >>> SH;
   // Only a sum of +N can exceed the positive range; -N maps exactly to the minimum.
   assign w_pos_ovf = !w_shift[ACC_W-1] && (|w_shift[ACC_W-2:BW-1]);
   assign w_result  = w_pos_ovf ? {1'b0, {(BW-1){1'b1}}} : w_shift[BW-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_ACCUM;
                  r_cnt   <= '0;
               end
            end
            ST_ACCUM: begin
               if (start) begin
                  r_cnt <= '0;
               end else if (in_valid) begin
                  r_cnt <= r_cnt + WINLOG'(1);
                  if (w_last) begin
                     r_state <= ST_HOLD;
                     r_out   <= w_result;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_cnt   <= '0;
                  r_state <= cont ? ST_ACCUM : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_ACCUM);
   assign out_valid = (r_state == ST_HOLD);
   assign busy      = (r_state != ST_IDLE);
   assign out_value = r_out;

endmodule

// File: tb/tb_bipolar_stream_decode.sv
// Randomized bench for bipolar_stream_decode against a sum-and-divide reference model.
module tb_bipolar_stream_decode;

   localparam int BW     = 8;
   localparam int WINLOG = 8;
   localparam int N      = 1 << WINLOG;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          cont;
   logic          in_valid;
   logic          bit_in;
   logic          in_ready;
   logic          out_ready;
   logic          out_valid;
   logic [BW-1:0] out_value;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int last_exp = 0;
   bit in_accum = 1'b0;

   always #5 clk = ~clk;

   bipolar_stream_decode #(
      .BW     (BW),
      .WINLOG (WINLOG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cont      (cont),
      .in_valid  (in_valid),
      .bit_in    (bit_in),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_value (out_value),
      .busy      (busy)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Reference: value = floor(sum * 2^(BW-1) / N), clamped to the positive maximum.
   function automatic int model_out(input int s);
      int d;
      int q;
      int maxv;
      d    = N / (1 << (BW - 1));
      q    = s / d;
      if (s < 0 && (s % d) != 0) q = q - 1;
      maxv = (1 << (BW - 1)) - 1;
      if (q > maxv) q = maxv;
      return q & ((1 << BW) - 1);
   endfunction

   task automatic open_window();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_accum = 1'b1;
      chk("retain_after_start", int'(out_value), last_exp);
   endtask

   // mode: 0 ones, 1 zeros, 2 alternating, 3 192 ones then zeros, other random.
   // vmode: 0 always valid, 1 low every third cycle, 2 random gaps.
   task automatic run_accum(input int mode, input int vmode, input int restart_at, input string tag);
      int sum = 0;
      int cnt = 0;
      int cyc = 0;
      int bad_rdy = 0;
      bit b;
      bit v;
      bit restarted = 1'b0;
      while (cnt < N && cyc < 4000) begin
         if (in_ready !== 1'b1) bad_rdy++;
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 3) != 2;
            default: v = $urandom_range(0, 3) != 0;
         endcase
         case (mode)
            0:       b = 1'b1;
            1:       b = 1'b0;
            2:       b = (cnt % 2) == 0;
            3:       b = cnt < 192;
            default: b = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         bit_in   = b;
         if (!restarted && restart_at > 0 && cnt == restart_at) begin
            start     = 1'b1;
            in_valid  = 1'b1;
            sum       = 0;
            cnt       = 0;
            restarted = 1'b1;
         end else if (v) begin
            sum += b ? 1 : -1;
            cnt++;
         end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      bit_in   = 1'b0;
      in_accum = 1'b0;
      chk({tag, "_bits_in_budget"}, cnt, N);
      chk({tag, "_in_ready_accum"}, bad_rdy, 0);
      last_exp = model_out(sum);
      chk({tag, "_out_valid"}, int'(out_valid), 1);
      chk({tag, "_out_value"}, int'(out_value), last_exp);
      chk({tag, "_in_ready_hold"}, int'(in_ready), 0);
   endtask

   task automatic handshake(input bit c, input string tag);
      out_ready = 1'b1;
      cont      = c;
      @(negedge clk);
      out_ready = 1'b0;
      cont      = 1'b0;
      in_accum  = c;
      chk({tag, "_out_valid_drop"}, int'(out_valid), 0);
      chk({tag, "_in_ready"}, int'(in_ready), int'(c));
      chk({tag, "_busy"}, int'(busy), int'(c));
      chk({tag, "_value_kept"}, int'(out_value), last_exp);
   endtask

   task automatic backpressure();
      int bad = 0;
      repeat (10) begin
         in_valid  = 1'b1;
         bit_in    = 1'($urandom_range(0, 1));
         start     = 1'b1;
         out_ready = 1'b0;
         @(negedge clk);
         if (out_valid !== 1'b1 || int'(out_value) != last_exp || in_ready !== 1'b0)
            bad++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("hold_stable", bad, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      cont      = 1'b0;
      in_valid  = 1'b0;
      bit_in    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_out_value", int'(out_value), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);

      in_valid = 1'b1;
      bit_in   = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("idle_ignores_bits", int'(busy), 0);

      open_window();
      run_accum(0, 0, -1, "ones");
      backpressure();
      handshake(1'b0, "hs_ones");

      open_window();
      run_accum(1, 0, -1, "zeros");
      handshake(1'b0, "hs_zeros");

      open_window();
      run_accum(2, 0, -1, "alt");
      handshake(1'b1, "hs_alt");
      run_accum(2, 1, -1, "alt_gap");
      handshake(1'b0, "hs_alt_gap");

      open_window();
      run_accum(3, 0, -1, "plus_half");
      handshake(1'b1, "hs_cont");
      run_accum(0, 2, 50, "restart");
      handshake(1'b0, "hs_restart");

      for (int i = 0; i < 6; i++) begin
         bit c;
         if (!in_accum) open_window();
         run_accum(4, 2, (i % 2 == 1) ? int'($urandom_range(1, 200)) : -1, "rnd");
         c = 1'($urandom_range(0, 1));
         handshake(c, "hs_rnd");
      end

      if (!in_accum) open_window();
      in_valid = 1'b1;
      bit_in   = 1'b1;
      repeat (100) @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_accum = 1'b0;
      last_exp = 0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_out_value", int'(out_value), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      open_window();
      run_accum(0, 0, -1, "post_rst");
      handshake(1'b0, "hs_post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bipolar_stream_decode.md
BIPOLAR_STREAM_DECODE -- requirements
Module: bipolar_stream_decode

Interface
REQ-001 SHALL have parameter BW, default 8: width of the signed binary output value.
REQ-002 SHALL have parameter WINLOG, default 8: window length N = 2^WINLOG bit-cycles; legal range WINLOG >= BW-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a new decode window.
REQ-006 SHALL have port cont, input, 1: continuous mode, sampled at output handshake.
REQ-007 SHALL have port in_valid, input, 1: bit_in qualifies this cycle.
REQ-008 SHALL have port bit_in, input, 1: bipolar stochastic bit (1 = +1, 0 = -1).
REQ-009 SHALL have port in_ready, output, 1: block accepts bits (high only in ACCUM).
REQ-010 SHALL have port out_ready, input, 1: downstream accepts out_value.
REQ-011 SHALL have port out_valid, output, 1: out_value holds a completed window result.
REQ-012 SHALL have port out_value, output, BW: two's-complement decoded value, full scale +/-1.0 = +/-2^(BW-1).
REQ-013 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-015 In IDLE, start=1 SHALL move to ACCUM next cycle with the accumulator and the window count cleared to 0.
REQ-016 In ACCUM, each cycle with in_valid=1 SHALL add +1 (bit_in=1) or -1 (bit_in=0) to a signed accumulator of width WINLOG+2 and increment the window count; in_valid=0 cycles SHALL change nothing.
REQ-017 The window count SHALL wrap from N-1 to 0; the accepted bit at count N-1 SHALL complete the window.
REQ-018 On window completion, the next cycle SHALL enter HOLD with out_valid=1 and out_value = final sum arithmetically shifted right by WINLOG-BW+1, truncating toward minus infinity.
REQ-019 A sum of +N SHALL saturate out_value to 2^(BW-1)-1; a sum of -N SHALL give -2^(BW-1) with no saturation.
REQ-020 In HOLD, out_value and out_valid SHALL stay stable until out_ready=1, in_ready SHALL be 0, and bit_in SHALL be ignored.
REQ-021 On handshake (HOLD, out_ready=1), out_valid SHALL drop next cycle; cont=1 SHALL go to ACCUM with cleared accumulator and count; cont=0 SHALL go to IDLE.
REQ-022 start=1 in ACCUM SHALL restart the window: accumulator and count cleared, and the bit presented in that cycle discarded.
REQ-023 start in HOLD SHALL be ignored.
REQ-024 out_value SHALL retain the last result after the handshake until the next window completes; only out_valid marks it as fresh.
REQ-025 in_ready SHALL be a pure decode of state==ACCUM; out_valid SHALL be a pure decode of state==HOLD.

Reset
REQ-026 rst_n=0 at a rising clk edge SHALL force state IDLE, accumulator 0, count 0, out_value 0, and therefore out_valid 0, in_ready 0, busy 0, regardless of state or other inputs.
REQ-027 Reset mid-window SHALL discard the partial sum; no result is produced for that window.

Structure
REQ-028 The state enum typedef and the shift/saturation width localparams SHALL live in a shared package, bipolar_stream_pkg.
REQ-029 The signed +/-1 accumulator with synchronous clear and enable SHALL be a sub-module, bipolar_updown_cnt (parameter width), reusable by the regeneration logic of other bipolar kernels.

Verification (BW=8, WINLOG=8, N=256)
REQ-030 256 ones with in_valid held high -> sum +256 -> out_value 0x7F (saturated), out_valid high.
REQ-031 256 zeros -> sum -256 -> out_value 0x80.
REQ-032 Alternating 1,0 for 256 bits -> out_value 0x00; the same pattern with in_valid low on every third cycle still yields 0x00 after 256 accepted bits.
REQ-033 192 ones then 64 zeros -> sum +128 -> out_value 0x40; with cont=1 and out_ready=1, the next window starts with in_ready high the following cycle.
REQ-034 Backpressure: out_ready held low 10 cycles in HOLD -> out_valid and out_value stable, in_ready 0, toggling bit_in has no effect; out_ready=1 with cont=0 -> IDLE, busy 0.
REQ-035 rst_n low after 100 bits -> next edge IDLE, out_value 0; a fresh start then decodes 256 ones to 0x7F.
